mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter for the single-port 512x16 data RAM.
- Lets a second bus master share the RAM with the CPU's mem_addr/mem_cmd interface. Typical second masters: the program loader, or a DMA/IO engine.
- Issues at most one RAM access per cycle.
- Tracks in-flight reads with an owner-tag pipeline, so each read returns to the port that issued it.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from the issue edge to valid ram_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_cmd  in  2  port 0 command: 00 none, 01 read, 10 write, 11 reserved (treated as none).
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_gnt  out  1  port 0 access accepted this cycle.
- req0_rvalid  out  1  port 0 read data valid.
- req0_rdata  out  DATA_W  port 0 read data.
- req1_cmd, req1_addr, req1_wdata, req1_gnt, req1_rvalid, req1_rdata: same as port 0, for port 1.
- ram_addr  out  ADDR_W  RAM address.
- ram_write  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Active request: cmd is 01 or 10. A requester holds cmd/addr/wdata stable until it sees its gnt high in the same cycle. It may change them or drop the request in the cycle after gnt.
- Grant is combinational from the cmd inputs and the last_winner register:
  - Only one port active: that port is granted.
  - Both active: the port that is not last_winner is granted.
  - Neither active: no grant; ram_write=0, ram_addr=0, ram_wdata=0.
- last_winner register:
  - Updates to the granted port at the clk edge of a grant cycle; otherwise holds.
  - Reset value is 1, so port 0 wins the first tie.
- Under continuous contention, grants strictly alternate. No port waits more than 1 cycle.
- RAM drive in the grant cycle: ram_addr = granted addr. ram_wdata = granted wdata. ram_write = 1 only for a write. A write takes effect at the closing clk edge.
- Read return:
  - A granted read loads a 2-bit tag {valid, port} into stage 0 of an RD_LAT-deep shift register.
  - The tag at the final stage drives reqN_rvalid for the matching port for exactly 1 cycle.
  - Return occurs RD_LAT cycles after the grant edge; with RD_LAT=1, rvalid is high in the cycle after gnt.
  - reqN_rdata = ram_rdata while that port's rvalid is high, else 0.
  - Back-to-back reads return in issue order, one per cycle. Reads from alternating ports return to alternating ports.
- Writes produce no rvalid.
- Read-after-write to the same address in the next cycle returns the new data. The RAM writes at the edge before the read is issued.
- Reserved cmd 11 produces no gnt, no RAM access and no change to last_winner.
- Reset, applied synchronously at any time including mid-read:
  - Clears all tag stages; no rvalid is asserted for reads issued before reset.
  - last_winner returns to 1.
  - While reset is high: all gnt=0, ram_write=0, all rvalid=0, all rdata=0.
- Reset values of outputs: gnt 0, rvalid 0, rdata 0, ram_write 0, ram_addr 0, ram_wdata 0.

Test Plan:
- Port 0 read, addr 9'h005, RAM[5]=16'hBEEF, RD_LAT=1 -> req0_gnt=1 that cycle; next cycle req0_rvalid=1, req0_rdata=16'hBEEF; req1_rvalid stays 0.
- Both ports read every cycle after reset (port 0 addr 1, port 1 addr 2) -> grants P0,P1,P0,P1; rvalid alternates one cycle later with RAM[1],RAM[2].
- Port 1 writes 16'h1234 to addr 9'h1FF, then port 0 reads 9'h1FF next cycle -> req0_rdata=16'h1234.
- Simultaneous port 0 write and port 1 read right after reset -> port 0 granted first (write); port 1 granted the next cycle; port 1 rvalid one cycle after that.
- Port 0 read granted, reset asserted the following cycle -> no rvalid on either port; after reset deasserts, a tie grants port 0.
- req0_cmd=11, req1_cmd=00 for 3 cycles -> no gnt, ram_write=0, last_winner unchanged (a later tie still grants port 0); repeat with RD_LAT=3 for a single read -> rvalid exactly 3 cycles after gnt.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the shared data RAM and mem_arbiter.
// The slave modport is the arbiter side; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [1:0]        req0_cmd;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_gnt;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;

  logic [1:0]        req1_cmd;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_gnt;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0_cmd, req0_addr, req0_wdata,
    input  req1_cmd, req1_addr, req1_wdata,
    input  ram_rdata,
    output req0_gnt, req0_rvalid, req0_rdata,
    output req1_gnt, req1_rvalid, req1_rdata,
    output ram_addr, ram_write, ram_wdata
  );

  modport master (
    output req0_cmd, req0_addr, req0_wdata,
    output req1_cmd, req1_addr, req1_wdata,
    output ram_rdata,
    input  req0_gnt, req0_rvalid, req0_rdata,
    input  req1_gnt, req1_rvalid, req1_rdata,
    input  ram_addr, ram_write, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single-port data RAM. Reads carry a
// {valid, port} tag down an RD_LAT-deep pipe so data returns to its issuer.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  logic                   act0_s, act1_s;
  logic                   gnt0_s, gnt1_s;
  logic                   rd_issue_s;
  logic [ADDR_W-1:0]      ram_addr_s;
  logic [DATA_W-1:0]      ram_wdata_s;
  logic                   ram_write_s;
  logic                   last_winner_q, last_winner_d;
  logic [RD_LAT-1:0][1:0] tag_q, tag_d;
  logic [1:0]             ret_tag_s;
  logic                   rvalid0_s, rvalid1_s;

  // Arbitration: last_winner=1 means port 1 won last, so port 0 takes a tie.
  always_comb begin
    act0_s      = ~reset & ((bus.req0_cmd == 2'b01) | (bus.req0_cmd == 2'b10));
    act1_s      = ~reset & ((bus.req1_cmd == 2'b01) | (bus.req1_cmd == 2'b10));
    gnt0_s      = act0_s & (~act1_s | last_winner_q);
    gnt1_s      = act1_s & (~act0_s | ~last_winner_q);
    ram_addr_s  = {ADDR_W{1'b0}};
    ram_wdata_s = {DATA_W{1'b0}};
    ram_write_s = 1'b0;
    rd_issue_s  = 1'b0;
    if (gnt0_s) begin
      ram_addr_s  = bus.req0_addr;
      ram_wdata_s = bus.req0_wdata;
      ram_write_s = (bus.req0_cmd == 2'b10);
      rd_issue_s  = (bus.req0_cmd == 2'b01);
    end else if (gnt1_s) begin
      ram_addr_s  = bus.req1_addr;
      ram_wdata_s = bus.req1_wdata;
      ram_write_s = (bus.req1_cmd == 2'b10);
      rd_issue_s  = (bus.req1_cmd == 2'b01);
    end else begin
      ram_addr_s  = {ADDR_W{1'b0}};
      ram_wdata_s = {DATA_W{1'b0}};
      ram_write_s = 1'b0;
      rd_issue_s  = 1'b0;
    end
  end

  // Next-state for the round-robin pointer and the read-owner tag pipe.
  always_comb begin
    if (gnt0_s) begin
      last_winner_d = 1'b0;
    end else if (gnt1_s) begin
      last_winner_d = 1'b1;
    end else begin
      last_winner_d = last_winner_q;
    end
    tag_d    = tag_q;
    tag_d[0] = {rd_issue_s, gnt1_s};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
      tag_q         <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      tag_q         <= tag_d;
    end
  end

  // Return path: final tag stage steers ram_rdata to its owner; silenced in reset.
  always_comb begin
    ret_tag_s = tag_q[RD_LAT-1];
    rvalid0_s = ~reset & ret_tag_s[1] & ~ret_tag_s[0];
    rvalid1_s = ~reset & ret_tag_s[1] &  ret_tag_s[0];
  end

  assign bus.req0_gnt    = gnt0_s;
  assign bus.req1_gnt    = gnt1_s;
  assign bus.ram_addr    = ram_addr_s;
  assign bus.ram_wdata   = ram_wdata_s;
  assign bus.ram_write   = ram_write_s;
  assign bus.req0_rvalid = rvalid0_s;
  assign bus.req1_rvalid = rvalid1_s;
  assign bus.req0_rdata  = rvalid0_s ? bus.ram_rdata : {DATA_W{1'b0}};
  assign bus.req1_rdata  = rvalid1_s ? bus.ram_rdata : {DATA_W{1'b0}};

endmodule
